abro_state_machine: RTL and testbench
=====================================

# abro_state_machine

Classic ABRO controller: waits for both events A and B in any order, including together, then emits a single-cycle O pulse. After that it stays done until reset restarts the sequence. The block is a small control primitive for sequencing logic that must react once to the joint occurrence of two independent events. All outputs are registered, and the current state is exported for observation and debug.

## Interface
- Parameters: none.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high; forces WAIT_AB and O=0 at the next rising edge; acts as the R event of ABRO.
- A  input  1  event A, level-sampled at each rising edge.
- B  input  1  event B, level-sampled at each rising edge.
- O  output  1  registered; high for exactly one cycle when both events have been seen.
- State  output  4  registered one-hot current state.

## Operation
- One-hot state encoding:
  - WAIT_AB = 4'b0001: no event seen yet.
  - WAIT_B = 4'b0010: A seen, B pending.
  - WAIT_A = 4'b0100: B seen, A pending.
  - DONE = 4'b1000: both seen.
- Transitions, evaluated at each rising edge when reset=0:
  - WAIT_AB: A&B -> DONE; A&!B -> WAIT_B; !A&B -> WAIT_A; otherwise stay.
  - WAIT_B: B -> DONE (A ignored); otherwise stay.
  - WAIT_A: A -> DONE (B ignored); otherwise stay.
  - DONE: stay regardless of A/B until reset.
- O is asserted in the same cycle as the first cycle of DONE: O_next = (next_state==DONE) && (state!=DONE). O is 0 in every other cycle.
- Reset:
  - Has priority over A/B.
  - State=WAIT_AB and O=0 after the edge, from any state, including mid-sequence (WAIT_A/WAIT_B) and during the O pulse.
- A and B are treated as levels. A held high across many cycles counts once. Re-asserting an event that was already recorded has no effect.
- Illegal or non-one-hot State values, unreachable in normal operation, recover to WAIT_AB at the next edge.
- Inputs are assumed synchronous to clk. No internal synchronizers.

## Timing
- Reset values: State=4'b0001, O=0.
- Latency: an input sampled at edge n is reflected in State/O after edge n. This is one cycle from input change to output.
- Fastest path: A=B=1 sampled in WAIT_AB gives State=DONE and O=1 after a single edge. O=0 after the following edge while State remains DONE.
- Sequential path:
  - A at edge n gives WAIT_B.
  - B at edge m>n gives DONE and O=1 after edge m.
  - Same for B-then-A via WAIT_A.
- Reset asserted at edge k gives State=WAIT_AB, O=0 after edge k, regardless of A/B. A new sequence can complete at edge k+1 earliest.
- No combinational path from inputs to outputs.

## Structure
- Shared package abro_pkg: state encoding constants WAIT_AB, WAIT_B, WAIT_A, DONE (4-bit one-hot) and the state width.
- Single module: one state register, next-state logic, and registered O. No sub-module is warranted.

## Test plan
- Reset:
  - Stimulus: hold reset=1 for 2 edges with A=B=1.
  - Required: State=4'b0001, O=0.
- Simultaneous events:
  - Stimulus: from WAIT_AB, apply A=1,B=1 for one edge.
  - Required: State=4'b1000, O=1; after the next edge O=0, State=4'b1000.
- A before B:
  - Stimulus: A=1,B=0 for one edge, then B=1 for one edge.
  - Required: State=4'b0010 then 4'b1000, with O=1 for one cycle only.
- B before A:
  - Stimulus: B=1,A=0 for one edge, then A=1 for one edge.
  - Required: State=4'b0100 then 4'b1000, with O a one-cycle pulse.
- Reset mid-sequence:
  - Stimulus: in WAIT_B (A seen), assert reset for one edge with B=1.
  - Required: State=4'b0001, O=0. Then A=B=1 for one edge gives DONE, O=1.
- Hold in DONE:
  - Stimulus: after completion, toggle A/B for 10 cycles.
  - Required: State stays 4'b1000, O stays 0, no second pulse until reset.

Source files
------------

// File: rtl/abro_pkg.sv
// Shared definitions for the ABRO controller: state width and the one-hot
// state encoding exported on the State port.
package abro_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    WAIT_AB = 4'b0001,  // no event seen yet
    WAIT_B  = 4'b0010,  // A seen, B pending
    WAIT_A  = 4'b0100,  // B seen, A pending
    DONE    = 4'b1000   // both seen, parked until reset
  } abro_state_e;

endpackage

// File: rtl/abro_state_machine.sv
// ABRO controller: waits for events A and B in any order (or together),
// emits a single-cycle registered O pulse on entry to DONE, then stays in
// DONE until the synchronous reset (the R event) restarts the sequence.
// Both outputs come straight from flops; there is no input-to-output
// combinational path.
module abro_state_machine
  import abro_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               A,
  input  logic               B,
  output logic               O,
  output logic [STATE_W-1:0] State
);

  abro_state_e state_q;
  abro_state_e state_d;
  logic        o_q;
  logic        o_d;

  // Next-state and pulse logic; any non-one-hot state falls back to WAIT_AB.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_AB: begin
        if (A && B)      state_d = DONE;
        else if (A)      state_d = WAIT_B;
        else if (B)      state_d = WAIT_A;
        else             state_d = WAIT_AB;
      end
      WAIT_B:  state_d = B ? DONE : WAIT_B;
      WAIT_A:  state_d = A ? DONE : WAIT_A;
      DONE:    state_d = DONE;
      default: state_d = WAIT_AB;
    endcase
    // O fires only on the transition into DONE, never while parked there.
    o_d = (state_d == DONE) && (state_q != DONE);
  end

  // State and O registers; reset has priority over A/B.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_AB;
      o_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
    end
  end

  assign State = state_q;
  assign O     = o_q;

endmodule

// File: tb/tb_abro_state_machine.sv
// Directed bench for abro_state_machine: linear sequence of steps, each
// applying inputs for one rising edge and checking State/O 1 ns afterward.
module tb_abro_state_machine;

  logic       clk;
  logic       reset;
  logic       A;
  logic       B;
  logic       O;
  logic [3:0] State;

  int checks;
  int errors;

  localparam logic [3:0] S_WAIT_AB = 4'b0001;
  localparam logic [3:0] S_WAIT_B  = 4'b0010;
  localparam logic [3:0] S_WAIT_A  = 4'b0100;
  localparam logic [3:0] S_DONE    = 4'b1000;

  abro_state_machine dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .O     (O),
    .State (State)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, settle 1 ns past it.
  task automatic step(input logic r, input logic a, input logic b);
    reset = r;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
  endtask

  // Compare State and O against hand-computed values.
  task automatic check(input string tag, input logic [3:0] st_exp, input logic o_exp);
    checks++;
    assert (State === st_exp && O === o_exp)
    else begin
      errors++;
      $error("FAIL %s: observed State=%b O=%b expected State=%b O=%b",
             tag, State, O, st_exp, o_exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    A      = 1'b1;
    B      = 1'b1;

    // Reset held two edges with A=B=1.
    step(1, 1, 1);
    step(1, 1, 1);
    check("reset", S_WAIT_AB, 1'b0);

    // Idle in WAIT_AB.
    step(0, 0, 0);
    check("idle_wait_ab", S_WAIT_AB, 1'b0);

    // No combinational path: inputs change, outputs must not move before the edge.
    A = 1'b1;
    B = 1'b1;
    #2;
    check("no_comb_path", S_WAIT_AB, 1'b0);

    // Simultaneous events.
    step(0, 1, 1);
    check("simul_done_pulse", S_DONE, 1'b1);
    step(0, 0, 0);
    check("simul_pulse_end", S_DONE, 1'b0);

    // A before B.
    step(1, 0, 0);
    check("reset_from_done", S_WAIT_AB, 1'b0);
    step(0, 1, 0);
    check("a_first_wait_b", S_WAIT_B, 1'b0);
    step(0, 0, 0);
    check("a_first_hold", S_WAIT_B, 1'b0);
    step(0, 1, 0);
    check("a_reassert_ignored", S_WAIT_B, 1'b0);
    step(0, 0, 1);
    check("a_first_done", S_DONE, 1'b1);
    step(0, 0, 1);
    check("a_first_pulse_end", S_DONE, 1'b0);

    // B before A; B still high when A arrives.
    step(1, 0, 0);
    check("reset_2", S_WAIT_AB, 1'b0);
    step(0, 0, 1);
    check("b_first_wait_a", S_WAIT_A, 1'b0);
    step(0, 0, 1);
    check("b_held_counts_once", S_WAIT_A, 1'b0);
    step(0, 1, 1);
    check("b_first_done", S_DONE, 1'b1);
    step(0, 0, 0);
    check("b_first_pulse_end", S_DONE, 1'b0);

    // A held high across several edges counts once.
    step(1, 0, 0);
    check("reset_3", S_WAIT_AB, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      check("a_held", S_WAIT_B, 1'b0);
    end
    step(0, 1, 1);
    check("a_held_then_b", S_DONE, 1'b1);

    // Reset during the O pulse, with A=B=1.
    step(1, 1, 1);
    check("reset_during_pulse", S_WAIT_AB, 1'b0);

    // Reset mid-sequence (WAIT_B) with B=1; then fastest completion.
    step(0, 1, 0);
    check("mid_wait_b", S_WAIT_B, 1'b0);
    step(1, 0, 1);
    check("reset_mid_sequence", S_WAIT_AB, 1'b0);
    step(0, 1, 1);
    check("after_mid_reset_done", S_DONE, 1'b1);

    // Hold in DONE: toggle A/B for 10 cycles, no second pulse.
    for (int i = 0; i < 10; i++) begin
      logic [1:0] pat;
      pat = i[1:0];
      step(0, pat[0], pat[1]);
      check("hold_done", S_DONE, 1'b0);
    end

    // Final reset restores WAIT_AB, then a WAIT_A path completes.
    step(1, 0, 0);
    check("final_reset", S_WAIT_AB, 1'b0);
    step(0, 0, 1);
    check("final_wait_a", S_WAIT_A, 1'b0);
    step(0, 1, 0);
    check("final_done", S_DONE, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
